// File: rtl/pipelined_rotate_unit.sv
// rtl/pipelined_rotate_unit.sv - log2(WIDTH)-stage pipelined rotate/shift unit with valid/ready
// Optional macro ROT_ZERO_FLAG_EN adds a registered zero flag on the result.
module pipelined_rotate_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o
`ifdef ROT_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;

    // One barrel step of s positions; SRA keeps the sign bit so the fill stays a[WIDTH-1] across stages.
    function automatic logic [WIDTH-1:0] move_by(input logic [WIDTH-1:0] d, input logic [1:0] f,
                                                 input int s);
        logic [WIDTH-1:0] r;
        case (f)
            OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
            OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
            OP_SRL:  r = d >> s;
            default: r = $signed(d) >>> s;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0]   data_q [SHAMT_W];
    logic [SHAMT_W-1:0] amt_q  [SHAMT_W];
    logic [1:0]         op_q   [SHAMT_W];
    logic [SHAMT_W-1:0] vld_q;

    logic [WIDTH-1:0]   data_d [SHAMT_W];
    logic [SHAMT_W-1:0] amt_d  [SHAMT_W];
    logic [1:0]         op_d   [SHAMT_W];
    logic [SHAMT_W-1:0] vld_d;

    logic adv;

    assign adv       = ~vld_q[SHAMT_W-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[SHAMT_W-1];
    assign o         = data_q[SHAMT_W-1];

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign amt_d[k]  = b[SHAMT_W-1:0];
            assign op_d[k]   = op;
            assign vld_d[k]  = in_valid;
            assign data_d[k] = amt_d[k][k] ? move_by(a, op, 1 << k) : a;
        end else begin : g_rest
            assign amt_d[k]  = amt_q[k-1];
            assign op_d[k]   = op_q[k-1];
            assign vld_d[k]  = vld_q[k-1];
            assign data_d[k] = amt_q[k-1][k] ? move_by(data_q[k-1], op_q[k-1], 1 << k)
                                             : data_q[k-1];
        end
    end

    // All stages share one advance so bubbles move in lockstep with real entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                op_q[k]   <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_d;
            for (int k = 0; k < SHAMT_W; k++) begin
                data_q[k] <= data_d[k];
                amt_q[k]  <= amt_d[k];
                op_q[k]   <= op_d[k];
            end
        end
    end

`ifdef ROT_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
        end else if (adv) begin
            zero <= (data_d[SHAMT_W-1] == '0);
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{b[WIDTH-1:SHAMT_W], amt_q[SHAMT_W-1], op_q[SHAMT_W-1]};

endmodule

// File: tb/tb_pipelined_rotate_unit.sv
// tb/tb_pipelined_rotate_unit.sv - self-checking bench for pipelined_rotate_unit
module tb_pipelined_rotate_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] o;
`ifdef ROT_ZERO_FLAG_EN
    logic         zero;
`endif

    pipelined_rotate_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .o        (o)
`ifdef ROT_ZERO_FLAG_EN
        ,
        .zero     (zero)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_out = 0;
    bit lat_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] exp;
        int           cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t head;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Bit-level reference: each result bit picks its source bit by position arithmetic.
    function automatic logic [W-1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                               input logic [1:0] rop);
        logic [W-1:0] r;
        int n;
        n = int'(rb % W);
        for (int i = 0; i < W; i++) begin
            case (rop)
                2'b00:   r[i] = ra[(i + n) % W];
                2'b01:   r[i] = ra[(i - n + W) % W];
                2'b10:   r[i] = (i + n < W) ? ra[i + n] : 1'b0;
                default: r[i] = (i + n < W) ? ra[i + n] : ra[W-1];
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected got=%h exp=none", o);
                end else begin
                    head = sbq.pop_front();
                    check("sb_data", o, head.exp);
                    if (lat_chk) check("sb_latency", W'(cyc - head.cyc), W'(5));
`ifdef ROT_ZERO_FLAG_EN
                    check("sb_zero", W'(zero), W'(head.exp == '0));
`endif
                end
            end
            if (in_valid && in_ready) sbq.push_back('{ref_model(a, b, op), cyc});
        end
    end

    task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [1:0] top);
        int  tries;
        bit  acc;
        tries = 0;
        acc = 1'b0;
        a = ta;
        b = tb_;
        op = top;
        in_valid = 1'b1;
        while (!acc && tries < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout got=in_ready_low exp=accept");
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, W'(sbq.size()), W'(0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        drive_op(v.a, v.b, v.op);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), W'(lat), W'(5));
        check($sformatf("vec%0d_data", idx), o, v.exp);
`ifdef ROT_ZERO_FLAG_EN
        check($sformatf("vec%0d_zero", idx), W'(zero), W'(v.exp == '0));
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] hold;
        int base;
        int seen;

        vecs[0] = '{32'h8000_0001, 32'd1,  2'b00, 32'hC000_0000};
        vecs[1] = '{32'h8000_0001, 32'd4,  2'b00, 32'h1800_0000};
        vecs[2] = '{32'h8000_0001, 32'd0,  2'b00, 32'h8000_0001};
        vecs[3] = '{32'h8000_0001, 32'd31, 2'b00, 32'h0000_0003};
        vecs[4] = '{32'h1234_5678, 32'h24, 2'b01, 32'h2345_6781};
        vecs[5] = '{32'hF000_0000, 32'd4,  2'b10, 32'h0F00_0000};
        vecs[6] = '{32'hF000_0000, 32'd4,  2'b11, 32'hFF00_0000};
        vecs[7] = '{32'h7000_0000, 32'd4,  2'b11, 32'h0700_0000};
        vecs[8] = '{32'h0000_0000, 32'd7,  2'b00, 32'h0000_0000};
        vecs[9] = '{32'h0000_0001, 32'd1,  2'b00, 32'h8000_0000};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_o", o, '0);
        check("reset_in_ready", W'(in_ready), W'(1));
`ifdef ROT_ZERO_FLAG_EN
        check("reset_zero", W'(zero), W'(0));
`endif
        @(posedge clk);
        #1;

        lat_chk = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
        wait_drain("vec_drain");

        for (int i = 0; i < W; i++) drive_op(32'h8000_0001, W'(i), 2'b00);
        wait_drain("sweep_drain");

        lat_chk = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom % 4) != 0;
            a         = $urandom;
            b         = $urandom;
            op        = 2'($urandom);
            out_ready = ($urandom % 3) != 0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain("random_drain");

        out_ready = 1'b0;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_op(32'hA500_0F00 + W'(i * 32'h1111), W'(i * 5), 2'(i));
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                check("bp_in_ready", W'(in_ready), W'(0));
                check("bp_out_valid", W'(out_valid), W'(1));
                hold = o;
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("bp_o_stable", o, hold);
                    check("bp_valid_stable", W'(out_valid), W'(1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        check("bp_count", W'(n_out - base), W'(8));

        lat_chk = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_op(32'hDEAD_BEEF + W'(i), W'(i + 3), 2'b01);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_flight_no_output", W'(seen), W'(0));
        check("rst_flight_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        run_vec(vecs[9], 9);
        wait_drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
